uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart of the RX parity/deserialiser path.
- Accepts one parallel word on a valid strobe and latches data plus parity config.
- Serialises one frame, LSB first: start bit (0), Data_Width data bits, optional parity bit, stop bit (1).
- Clocked by the TX baud clock, so one bit is sent per clk cycle. Sits between the TX async FIFO read side and the serial line.

Parameters:
- Data_Width, 8, payload bits per frame (4..16).

Ports:
- clk  input  1  TX baud clock; one serial bit per rising edge.
- rst  input  1  Reset. Asynchronous, active-low.
- P_Data  input  Data_Width  Parallel word to send. Sampled only on accept.
- Data_Valid  input  1  Word-present strobe. Accepted only in IDLE.
- Par_En  input  1  1 = insert parity bit. Sampled on accept.
- Par_Type  input  1  0 = even, 1 = odd. Sampled on accept.
- TX_OUT  output  1  Serial line, registered. Idles high.
- Busy  output  1  High while a frame is in flight, registered.

Behaviour:
- Reset (rst=0, asynchronous): TX_OUT=1, Busy=0, state=IDLE, bit counter=0, shadow registers cleared. Applies immediately, including mid-frame; the partial frame is abandoned and no recovery frame is sent.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at a clk edge: latch P_Data, Par_En and Par_Type into shadow registers. Compute parity from the latched data: even = ^data, odd = ~^data.
  - Go to START. TX_OUT=0 and Busy=1 take effect in the same edge, so latency from accept edge to start bit is 0 cycles after the edge.
- START: one cycle, TX_OUT=0. Go to DATA with counter=0.
- DATA:
  - TX_OUT = data[counter], LSB first; counter increments each cycle.
  - After bit Data_Width-1: go to PARITY if latched Par_En=1, else STOP.
  - Counter width is $clog2(Data_Width); it must never exceed Data_Width-1.
- PARITY: one cycle, TX_OUT = latched parity bit. Go to STOP.
- STOP:
  - One cycle, TX_OUT=1.
  - Next state is IDLE with Busy=0. If Data_Valid=1 in that IDLE cycle, the next frame starts, so the minimum gap is 1 idle cycle.
- Frame length from the start-bit cycle: Data_Width+3 cycles with parity, Data_Width+2 without.
- Data_Valid while Busy=1 is ignored (no queueing, no error). The upstream side must hold Data_Valid until it sees Busy rise.
- Changes on P_Data, Par_En or Par_Type mid-frame have no effect on the current frame.
- Outputs are glitch-free: TX_OUT and Busy are driven only from flops.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles (internal 1-bit stop counter). Frame length is Data_Width+4 with parity, Data_Width+3 without. Busy stays high through both stop cycles.
- Undefined: single stop bit as above; no stop counter logic is synthesised.

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - Parity-type constants: EVEN=1'b0, ODD=1'b1.
  - Start/stop line levels.
  - The package is reused by the RX side.
- One natural sub-module: uart_tx_parity_calc. It is combinational and computes the parity bit from data and Par_Type, mirroring the RX checker's equation. The FSM, counter and serialiser mux stay in uart_tx_frame.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, release, Data_Valid=0 for 20 cycles -> TX_OUT=1 and Busy=0 throughout.
- Even parity: P_Data=8'hA5, Par_En=1, Par_Type=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity=0, stop). Busy high for exactly 11 cycles.
- Odd parity: P_Data=8'hA5, Par_En=1, Par_Type=1 -> parity bit=1. Then P_Data=8'h01 with even parity -> parity bit=1.
- No parity, back-to-back: Par_En=0, two words 8'hFF then 8'h00 with Data_Valid held -> each frame is 10 cycles, with exactly 1 idle-high cycle between frames. The second frame data bits are all 0.
- Mid-frame changes: change P_Data and Par_Type during the DATA state and pulse Data_Valid while Busy=1 -> current frame unchanged, no extra frame sent.
- Reset mid-frame: assert rst during data bit 3 -> TX_OUT=1 and Busy=0 asynchronously. After release, a new 8'h3C frame transmits cleanly. With UART_TX_TWO_STOP_EN, the same frame shows two stop cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type and line levels.
// Reused by both the TX framer and the RX deserialiser.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even = ^data, odd = ~^data.
// Same equation as the RX parity checker so both ends agree by construction.
module uart_tx_parity_calc
   import uart_pkg::*;
#(
   parameter int Data_Width = 8
) (
   input  logic [Data_Width-1:0] data,
   input  logic                  par_type,
   output logic                  par_bit
);

   // Parity bit for the latched word; odd type inverts the XOR reduction.
   always_comb begin
      par_bit = ^data;
      if (par_type == ODD) begin
         par_bit = ~^data;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, Data_Width data bits LSB first,
// optional parity bit, stop bit. One serial bit per clk (baud clock).
// Build option: define UART_TX_TWO_STOP_EN for two stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid; word latched on accept
// START  | start bit (0) on the line
// DATA   | data[cnt] on the line, cnt counts 0..Data_Width-1
// PARITY | latched parity bit on the line
// STOP   | stop bit (1); two cycles when UART_TX_TWO_STOP_EN is defined
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int Data_Width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [Data_Width-1:0] P_Data,
   input  logic                  Data_Valid,
   input  logic                  Par_En,
   input  logic                  Par_Type,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = $clog2(Data_Width);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Data_Width - 1);

   tx_state_t             state;
   logic [Data_Width-1:0] data_q;
   logic                  par_en_q;
   logic                  par_type_q;
   logic                  par_bit;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nxt;
`ifdef UART_TX_TWO_STOP_EN
   logic                  stop_cnt;
`endif

   assign cnt_nxt = cnt + CNT_W'(1);

   uart_tx_parity_calc #(
      .Data_Width (Data_Width)
   ) u_parity (
      .data     (data_q),
      .par_type (par_type_q),
      .par_bit  (par_bit)
   );

   // Frame sequencer; TX_OUT and Busy are registered so the line never glitches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= EVEN;
         TX_OUT     <= LINE_IDLE;
         Busy       <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               TX_OUT <= LINE_IDLE;
               Busy   <= 1'b0;
               if (Data_Valid) begin
                  data_q     <= P_Data;
                  par_en_q   <= Par_En;
                  par_type_q <= Par_Type;
                  state      <= START;
                  TX_OUT     <= LINE_START;
                  Busy       <= 1'b1;
               end
            end
            START: begin
               state  <= DATA;
               cnt    <= '0;
               TX_OUT <= data_q[0];
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (par_en_q) begin
                     state  <= PARITY;
                     TX_OUT <= par_bit;
                  end else begin
                     state  <= STOP;
                     TX_OUT <= LINE_STOP;
                  end
               end else begin
                  cnt    <= cnt_nxt;
                  TX_OUT <= data_q[cnt_nxt];
               end
            end
            PARITY: begin
               state  <= STOP;
               TX_OUT <= LINE_STOP;
            end
            STOP: begin
               TX_OUT <= LINE_STOP;
`ifdef UART_TX_TWO_STOP_EN
               if (!stop_cnt) begin
                  stop_cnt <= 1'b1;
               end else begin
                  stop_cnt <= 1'b0;
                  state    <= IDLE;
                  Busy     <= 1'b0;
               end
`else
               state <= IDLE;
               Busy  <= 1'b0;
`endif
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= LINE_IDLE;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame (Data_Width = 8). Expected line
// sequences are hand-written strings, first character = start bit.
// Honours UART_TX_TWO_STOP_EN by appending a second stop bit.
module tb_uart_tx_frame;

   logic       clk;
   logic       rst;
   logic [7:0] P_Data;
   logic       Data_Valid;
   logic       Par_En;
   logic       Par_Type;
   logic       TX_OUT;
   logic       Busy;

   int checks   = 0;
   int failures = 0;

`ifdef UART_TX_TWO_STOP_EN
   localparam string XSTOP = "1";
`else
   localparam string XSTOP = "";
`endif

   uart_tx_frame #(.Data_Width(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_Data     (P_Data),
      .Data_Valid (Data_Valid),
      .Par_En     (Par_En),
      .Par_Type   (Par_Type),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check($sformatf("%s_tx[%0d]", tag, i), TX_OUT, 1'b1);
         check($sformatf("%s_busy[%0d]", tag, i), Busy, 1'b0);
      end
   endtask

   // Called one step after a posedge while the DUT is idle and Data_Valid=1.
   // Checks every frame cycle, then the single idle cycle that follows.
   task automatic frame(input string tag, input string bits, input logic keep_dv,
                        input logic [7:0] alt_data, input logic alt_type,
                        input int pulse_at);
      for (int i = 0; i < bits.len(); i++) begin
         step();
         if (i == 0) begin
            P_Data   = alt_data;
            Par_Type = alt_type;
            if (!keep_dv) Data_Valid = 1'b0;
         end
         if (i == pulse_at) Data_Valid = 1'b1;
         else if (i == pulse_at + 1) Data_Valid = 1'b0;
         check($sformatf("%s_tx[%0d]", tag, i), TX_OUT, bits[i] == "1");
         check($sformatf("%s_busy[%0d]", tag, i), Busy, 1'b1);
      end
      step();
      check($sformatf("%s_gap_tx", tag), TX_OUT, 1'b1);
      check($sformatf("%s_gap_busy", tag), Busy, 1'b0);
   endtask

   initial begin
      rst        = 1'b0;
      P_Data     = 8'h00;
      Data_Valid = 1'b0;
      Par_En     = 1'b0;
      Par_Type   = 1'b0;

      // Reset held for three cycles, then twenty idle cycles.
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst_tx[%0d]", i), TX_OUT, 1'b1);
         check($sformatf("rst_busy[%0d]", i), Busy, 1'b0);
      end
      rst = 1'b1;
      check_idle("idle", 20);

      // 8'hA5, even parity: parity 0, eleven busy cycles.
      P_Data = 8'hA5; Par_En = 1'b1; Par_Type = 1'b0; Data_Valid = 1'b1;
      frame("a5_even", {"01010010101", XSTOP}, 1'b0, 8'hA5, 1'b0, -5);
      check_idle("post_a5_even", 2);

      // 8'hA5, odd parity: parity 1.
      P_Data = 8'hA5; Par_En = 1'b1; Par_Type = 1'b1; Data_Valid = 1'b1;
      frame("a5_odd", {"01010010111", XSTOP}, 1'b0, 8'hA5, 1'b1, -5);

      // 8'h01, even parity: single one bit so parity 1.
      P_Data = 8'h01; Par_En = 1'b1; Par_Type = 1'b0; Data_Valid = 1'b1;
      frame("01_even", {"01000000011", XSTOP}, 1'b0, 8'h01, 1'b0, -5);
      check_idle("post_01", 2);

      // No parity, back-to-back with Data_Valid held: one idle cycle between.
      P_Data = 8'hFF; Par_En = 1'b0; Par_Type = 1'b0; Data_Valid = 1'b1;
      frame("ff_nopar", {"0111111111", XSTOP}, 1'b1, 8'h00, 1'b0, -5);
      frame("00_nopar", {"0000000001", XSTOP}, 1'b0, 8'h00, 1'b0, -5);
      check_idle("post_b2b", 3);

      // Mid-frame P_Data/Par_Type change and a Data_Valid pulse while busy.
      P_Data = 8'h0F; Par_En = 1'b1; Par_Type = 1'b0; Data_Valid = 1'b1;
      frame("midchg", {"01111000001", XSTOP}, 1'b0, 8'hF3, 1'b1, 4);
      check_idle("no_extra", 6);

      // Reset asserted during data bit 3 of an A5 frame (bit 3 = 0).
      P_Data = 8'hA5; Par_En = 1'b1; Par_Type = 1'b0; Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      check("abort_start_tx", TX_OUT, 1'b0);
      for (int i = 0; i < 4; i++) step();
      check("abort_bit3_tx", TX_OUT, 1'b0);
      check("abort_bit3_busy", Busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_tx", TX_OUT, 1'b1);
      check("async_rst_busy", Busy, 1'b0);
      step();
      step();
      rst = 1'b1;
      check_idle("post_rst", 3);

      // Clean 8'h3C frame after reset, even parity (four ones -> 0).
      P_Data = 8'h3C; Par_En = 1'b1; Par_Type = 1'b0; Data_Valid = 1'b1;
      frame("3c_even", {"00011110001", XSTOP}, 1'b0, 8'h3C, 1'b0, -5);
      check_idle("end", 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
